// File: rtl/rr_arb_burst.sv
// Round-robin N-way arbiter that holds a registered one-hot grant for a whole burst.
// Latency: grant is registered, so it appears one cycle after the request or release that selects it.
// Backpressure: beats advance only on ack; a MAX_HOLD beat limit force-releases long bursts.
module rr_arb_burst #(
  parameter int N        = 4,
  parameter int MAX_HOLD = 16,
  parameter int IDW      = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N-1:0]   req,
  input  logic [N-1:0]   req_last,
  input  logic           ack,
  output logic [N-1:0]   grant,
  output logic           grant_valid,
  output logic [IDW-1:0] grant_id,
  output logic           preempt
);

  // With preemption disabled the counter is never used, so keep it one bit wide.
  localparam int CW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;

  typedef enum logic {IDLE = 1'b0, OWN = 1'b1} state_t;

  state_t         state, state_nxt;
  logic [N-1:0]   grant_nxt;
  logic [IDW-1:0] id_nxt;
  logic [IDW-1:0] last_ptr, last_ptr_nxt;
  logic [CW-1:0]  cnt, cnt_nxt;
  logic           preempt_nxt;

  logic           beat, rel_last, rel_drop, rel_max, release_now;
  logic [IDW-1:0] arb_ptr;
  logic [2*N-1:0] req_dbl;
  logic [N-1:0]   req_rot;
  logic           win_found;
  logic [IDW-1:0] win_id;
  logic [N-1:0]   win_oh;
  int             win_idx;

  assign grant_valid = (state == OWN);
  assign beat        = ack && grant_valid;
  assign rel_last    = beat && req_last[grant_id];
  assign rel_drop    = !req[grant_id];
  assign rel_max     = (MAX_HOLD != 0) && beat && (cnt == CW'(MAX_HOLD - 1));
  assign release_now = grant_valid && (rel_last || rel_drop || rel_max);

  // While owning, a release rotates from the current owner; when idle, from the last served.
  assign arb_ptr = grant_valid ? grant_id : last_ptr;

  // Rotate the request vector so bit 0 is the highest-priority requester.
  assign req_dbl = {req, req} >> ({1'b0, arb_ptr} + 1'b1);
  assign req_rot = req_dbl[N-1:0];

  // Pick the first requester in rotated order and map it back to an absolute index.
  always_comb begin
    win_found = 1'b0;
    win_idx   = 0;
    for (int i = 0; i < N; i++) begin
      if (!win_found && req_rot[i]) begin
        win_found = 1'b1;
        win_idx   = int'(arb_ptr) + 1 + i;
      end
    end
    if (win_idx >= N) win_idx = win_idx - N;
    win_id    = IDW'(win_idx);
    win_oh    = '0;
    win_oh[win_id] = 1'b1;
  end

  // Next-state, next-grant, hold counter and preempt pulse.
  always_comb begin
    state_nxt    = state;
    grant_nxt    = grant;
    id_nxt       = grant_id;
    last_ptr_nxt = last_ptr;
    cnt_nxt      = cnt;
    preempt_nxt  = 1'b0;
    if (state == IDLE) begin
      if (win_found) begin
        state_nxt = OWN;
        grant_nxt = win_oh;
        id_nxt    = win_id;
      end
    end else begin
      if (release_now) begin
        last_ptr_nxt = grant_id;
        cnt_nxt      = '0;
        // A last beat landing on the limit is a normal completion, not a preemption.
        preempt_nxt  = rel_max && !rel_last;
        if (win_found) begin
          grant_nxt = win_oh;
          id_nxt    = win_id;
        end else begin
          state_nxt = IDLE;
          grant_nxt = '0;
          id_nxt    = '0;
        end
      end else if (beat && (MAX_HOLD != 0)) begin
        cnt_nxt = cnt + 1'b1;
      end
    end
  end

  // State and output registers; reset leaves requester 0 at top priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      grant    <= '0;
      grant_id <= '0;
      last_ptr <= IDW'(N - 1);
      cnt      <= '0;
      preempt  <= 1'b0;
    end else begin
      state    <= state_nxt;
      grant    <= grant_nxt;
      grant_id <= id_nxt;
      last_ptr <= last_ptr_nxt;
      cnt      <= cnt_nxt;
      preempt  <= preempt_nxt;
    end
  end

endmodule

// File: doc/rr_arb_burst.md
Name: rr_arb_burst

Overview:
- Parametrised N-way round-robin arbiter with a registered one-hot grant.
- A grant is held for a multi-beat burst: beats transfer on ack and the burst closes on req_last.
- A MAX_HOLD beat limit preempts long bursts so no requester starves.
- Sits in front of a shared resource (bus, memory port, FIFO write side) where a requester must keep ownership for a whole transaction.

Parameters:
- N, 4: number of requesters; must be at least 2.
- MAX_HOLD, 16: maximum acked beats per grant before forced release; 0 disables preemption.
- IDW, $clog2(N): width of grant_id; derived, do not override.

Ports:
- clk  input  1  clock
- rst_n  input  1  reset, asynchronous, active-low
- req  input  N  per-requester request level
- req_last  input  N  per-requester last-beat flag; only the granted bit is used
- ack  input  1  downstream accepts a beat this cycle
- grant  output  N  registered one-hot grant; all zeros when idle
- grant_valid  output  1  OR of grant (registered)
- grant_id  output  IDW  binary index of the granted requester; 0 when idle
- preempt  output  1  one-cycle pulse: the previous grant was force-released by MAX_HOLD

Behaviour:
- Reset (async assert, sync deassert) forces all of the following immediately:
  - grant=0, grant_valid=0, grant_id=0, preempt=0.
  - Hold counter cleared.
  - last_ptr=N-1, so requester 0 has top priority first.
- States: IDLE (grant_valid=0) and OWN (grant_valid=1).
- Priority order is last_ptr+1, last_ptr+2, ... wrapping modulo N.
  - The last-served requester therefore has lowest priority but is still eligible.
- IDLE:
  - Any req bit high at edge t: the winner is registered at edge t, so grant is visible in cycle t+1 (1-cycle latency); go to OWN.
  - No req: stay IDLE.
- OWN, with a beat defined as ack && grant_valid:
  - A beat increments the hold counter.
  - ack while IDLE is ignored.
- A release happens at an edge when any of these hold:
  - (a) beat && req_last[grant_id]
  - (b) req[grant_id]==0, a requester drop; an ack in the same cycle still counts as a transferred beat
  - (c) MAX_HOLD!=0 && beat && counter==MAX_HOLD-1, i.e. the MAX_HOLD-th beat
- On release:
  - last_ptr <= grant_id and the hold counter clears.
  - Arbitration runs in the same cycle using the current req vector and the updated rotation (start at grant_id+1).
  - The new winner is granted back-to-back in the next cycle with no idle bubble. If no req is high, go to IDLE.
  - Under (a) or (b), the released requester wins again only if it is the sole requester (natural rotation).
  - Under (c), the preempted requester, if still requesting, competes at lowest priority.
- preempt is 1 in the cycle after a (c) release, whether or not a new grant follows, and 0 otherwise.
  - If (a) and (c) coincide, (a) takes precedence and preempt stays 0.
- Requests arriving or changing during OWN never change grant until a release.
- grant is always one-hot or zero; grant_id is consistent with grant in the same cycle.
- Hold counter width is $clog2(MAX_HOLD+1). It saturates logically via the release, so it never wraps.
- Reset mid-burst: grant drops asynchronously, and the burst is abandoned with no completion signalling.

Test Plan (N=4, MAX_HOLD=4 unless noted):
- Reset, then req=4'b1111 at edge 1 -> cycle 2: grant=4'b0001, grant_id=0, grant_valid=1; during reset all outputs 0.
- req=4'b1111 held, ack=1 and req_last=4'b1111 every cycle -> grant sequence 0001,0010,0100,1000,0001 on consecutive cycles; preempt stays 0.
- req0 burst of 3 beats with ack pattern 1,0,1,1 (last on the 3rd beat), req1 raised during the burst -> grant stays 0001 through the stall; grant=0010 the cycle after the req_last beat.
- req0 and req2 high, req_last=0, ack=1 every cycle -> grant=0001 for exactly 4 beats, then grant=0100 with preempt=1 for that one cycle; after req2 finishes, req0 is regranted with the counter restarted at 0.
- Granted req1 drops req with no last and req=0 elsewhere -> next cycle grant=0, grant_valid=0, and a later lone req1 gives grant=0010. With MAX_HOLD=0, a 100-beat burst is never preempted.
- Async rst_n low mid-burst (grant=0100) -> grant=0 without waiting for clk; after release, req=4'b1010 -> grant=0010, since last_ptr was reset.
